mmio_timer: RTL



---
 rtl/mmio_timer_pkg.sv | 24 ++
 rtl/mmio_timer_prescaler.sv | 36 +++
 rtl/mmio_timer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mmio_timer_pkg.sv
// Shared constants and types for the memory-mapped timer peripheral.
package mmio_timer_pkg;

   // Register offsets from the peripheral base address.
   localparam logic [2:0] TmrCtrl     = 3'd0;
   localparam logic [2:0] TmrPrescale = 3'd1;
   localparam logic [2:0] TmrCompare  = 3'd2;
   localparam logic [2:0] TmrCount    = 3'd3;
   localparam logic [2:0] TmrStatus   = 3'd4;

   // Highest mapped offset; anything above is not decoded.
   localparam logic [15:0] TmrLastOffset = 16'd4;

   // CTRL bit positions.
   localparam int unsigned CtrlEnBit   = 0;
   localparam int unsigned CtrlAutoBit = 1;

   // Run state is not stored separately; it is derived from CTRL.EN.
   typedef enum logic {
      StIdle,
      StRun
   } tmr_state_t;

endpackage

// File: rtl/mmio_timer_prescaler.sv
// Prescaler: counts clocks while running and emits a tick every prescale_i+1 clocks.
module mmio_timer_prescaler (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        run_i,
   input  logic        clear_i,
   input  logic [15:0] prescale_i,
   output logic        tick_o
);

   logic [15:0] psc_q, psc_d;

   assign tick_o = run_i && (psc_q == prescale_i);

   // Next prescaler count: held at zero when idle or cleared, wraps on tick.
   always_comb begin
      psc_d = psc_q;
      if (!run_i || clear_i) begin
         psc_d = '0;
      end else if (tick_o) begin
         psc_d = '0;
      end else begin
         psc_d = psc_q + 16'd1;
      end
   end

   // Prescaler state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         psc_q <= '0;
      end else begin
         psc_q <= psc_d;
      end
   end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped 16-bit timer with prescaler, compare match, one-shot or auto-reload
// modes and a read-to-clear match flag, sharing the datapath memory bus.
module mmio_timer
   import mmio_timer_pkg::*;
#(
   parameter logic [15:0] BASE = 16'h2010
) (
   input  logic        clock,
   input  logic        reset_L,
   input  logic [15:0] memAddr,
   input  logic        re_L,
   input  logic        we_L,
   inout  wire  [15:0] dataBus,
   output logic        match_L
);

   logic [1:0]  ctrl_q, ctrl_d;
   logic [15:0] prescale_q, prescale_d;
   logic [15:0] compare_q, compare_d;
   logic [15:0] count_q, count_d;
   logic        flag_q, flag_d;
   logic        match_nq, match_nd;

   logic [15:0] offset;
   logic [2:0]  reg_sel;
   logic        hit, rd_en, wr_en;
   logic        wr_ctrl, wr_prescale, wr_compare, wr_count, rd_status;
   logic        tick, match, auto_mode;
   logic [15:0] rd_data;
   tmr_state_t  state;

   // Address decode; the subtraction wraps so addresses below BASE never hit.
   assign offset      = memAddr - BASE;
   assign hit         = (offset <= TmrLastOffset);
   assign reg_sel     = offset[2:0];
   assign rd_en       = !re_L && hit;
   assign wr_en       = !we_L && hit;
   assign wr_ctrl     = wr_en && (reg_sel == TmrCtrl);
   assign wr_prescale = wr_en && (reg_sel == TmrPrescale);
   assign wr_compare  = wr_en && (reg_sel == TmrCompare);
   assign wr_count    = wr_en && (reg_sel == TmrCount);
   assign rd_status   = rd_en && (reg_sel == TmrStatus);

   assign state     = ctrl_q[CtrlEnBit] ? StRun : StIdle;
   assign auto_mode = ctrl_q[CtrlAutoBit];

   mmio_timer_prescaler u_prescaler (
      .clk_i      (clock),
      .rst_ni     (reset_L),
      .run_i      (state == StRun),
      .clear_i    (wr_prescale),
      .prescale_i (prescale_q),
      .tick_o     (tick)
   );

   assign match = tick && (count_q == compare_q);

   // Read mux; only consulted while a read is decoded.
   always_comb begin
      rd_data = '0;
      case (reg_sel)
         TmrCtrl:     rd_data = {14'd0, ctrl_q};
         TmrPrescale: rd_data = prescale_q;
         TmrCompare:  rd_data = compare_q;
         TmrCount:    rd_data = count_q;
         TmrStatus:   rd_data = {15'd0, flag_q};
         default:     rd_data = '0;
      endcase
   end

   assign dataBus = rd_en ? rd_data : 16'hzzzz;
   assign match_L = match_nq;

   // Next-state: CPU writes take priority over tick-driven updates.
   always_comb begin
      ctrl_d     = ctrl_q;
      prescale_d = prescale_q;
      compare_d  = compare_q;
      count_d    = count_q;
      flag_d     = flag_q;
      match_nd   = !match;

      if (wr_ctrl) begin
         ctrl_d = dataBus[1:0];
      end else if (match && !auto_mode) begin
         ctrl_d[CtrlEnBit] = 1'b0;
      end

      if (wr_prescale) prescale_d = dataBus;
      if (wr_compare)  compare_d  = dataBus;

      if (wr_count) begin
         count_d = dataBus;
      end else if (tick) begin
         if (match) begin
            count_d = auto_mode ? 16'd0 : count_q;
         end else begin
            count_d = count_q + 16'd1;
         end
      end

      // A match on the same edge as a clearing read leaves the flag set.
      if (rd_status) flag_d = 1'b0;
      if (match)     flag_d = 1'b1;
   end

   // Register file and registered match pulse.
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         ctrl_q     <= '0;
         prescale_q <= '0;
         compare_q  <= 16'hFFFF;
         count_q    <= '0;
         flag_q     <= 1'b0;
         match_nq   <= 1'b1;
      end else begin
         ctrl_q     <= ctrl_d;
         prescale_q <= prescale_d;
         compare_q  <= compare_d;
         count_q    <= count_d;
         flag_q     <= flag_d;
         match_nq   <= match_nd;
      end
   end

endmodule
